// File: rtl/alu_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_pkg
// Purpose  : Shared types and helpers for the iterative radix-4 Booth
//            integer multiplier (mul_int_iter and mul_booth_step).
//            - mul_op_e    : RISC-V result-half / signedness selector
//            - state_e     : control FSM states
//            - booth_sel_t : one-hot partial-product select
//            - booth_digit : radix-4 Booth recoding of one bit triplet
// Revision : 1.0  initial release
// ============================================================================
package alu_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One-hot select; all-zero means the digit contributes nothing.
  typedef struct packed {
    logic neg2x;
    logic neg1x;
    logic pos2x;
    logic pos1x;
  } booth_sel_t;

  // Triplet is {b[2k+1], b[2k], b[2k-1]}; digit value = -2*t2 + t1 + t0.
  function automatic booth_sel_t booth_digit(input logic [2:0] trip, output logic neg);
    booth_sel_t sel;
    sel = '0;
    case (trip)
      3'b001, 3'b010: sel.pos1x = 1'b1;
      3'b011:         sel.pos2x = 1'b1;
      3'b100:         sel.neg2x = 1'b1;
      3'b101, 3'b110: sel.neg1x = 1'b1;
      default:        sel = '0;
    endcase
    neg = sel.neg2x | sel.neg1x;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_booth_step.sv
`default_nettype none
// ============================================================================
// Module   : mul_booth_step
// Purpose  : Combinational accumulation of DIGITS_PER_CYC radix-4 Booth
//            partial products into a 2*WIDTH+4-bit accumulator.
// Ports    : i_acc   accumulator before this step
//            i_a_ext multiplicand, already extended to WIDTH+2 bits
//            i_trip  one Booth triplet per digit slot (slot 0 in LSBs)
//            i_base  digit index of slot 0
//            o_acc   accumulator after this step
// Revision : 1.0  initial release
// ============================================================================
module mul_booth_step
  import alu_mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DIGITS_PER_CYC = 2,
  parameter int CNT_W          = 5
) (
  input  logic [2*WIDTH+3:0]          i_acc,
  input  logic [WIDTH+1:0]            i_a_ext,
  input  logic [3*DIGITS_PER_CYC-1:0] i_trip,
  input  logic [CNT_W-1:0]            i_base,
  output logic [2*WIDTH+3:0]          o_acc
);

  localparam int c_ew = WIDTH + 2;
  localparam int c_aw = 2*WIDTH + 4;
  localparam int c_n  = (WIDTH + 2) / 2;

  logic [c_aw-1:0] w_a_sx;

  assign w_a_sx = {{(c_aw-c_ew){i_a_ext[c_ew-1]}}, i_a_ext};

  // Partial product for digit k, aligned to bit 2k. Negation is ~x with the
  // +1 injected at bit 2k, which equals -(x << 2k) modulo 2^c_aw.
  function automatic logic [c_aw-1:0] pp_term(input logic [c_aw-1:0] a_sx,
                                              input logic [2:0] trip,
                                              input int k);
    booth_sel_t      sel;
    logic            neg;
    logic [c_aw-1:0] mag;
    logic [c_aw-1:0] one;
    sel = booth_digit(trip, neg);
    mag = '0;
    one = '0;
    if (sel.pos1x || sel.neg1x)
      mag = a_sx;
    else if (sel.pos2x || sel.neg2x)
      mag = a_sx << 1;
    if (neg) begin
      mag    = ~mag;
      one[0] = 1'b1;
    end
    return (mag << (2*k)) + (one << (2*k));
  endfunction

  // Slots past the last digit (final, partial step) contribute nothing.
  always_comb begin
    o_acc = i_acc;
    for (int j = 0; j < DIGITS_PER_CYC; j++) begin
      if (int'(i_base) + j < c_n)
        o_acc = o_acc + pp_term(w_a_sx, i_trip[3*j +: 3], int'(i_base) + j);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_int_iter.sv
`default_nettype none
// ============================================================================
// Module   : mul_int_iter
// Purpose  : Iterative radix-4 Booth integer multiplier with valid/ready
//            handshake, kill, and MUL/MULH/MULHSU/MULHU result selection.
// Ports    : clk_i, rst_i           clock, synchronous active-high reset
//            in_vld_i / in_rdy_o    request handshake (op_i, a_i, b_i)
//            kill_i                 abort in-flight op, blocks acceptance
//            out_vld_o / out_rdy_i  result handshake (res_o)
// Revision : 1.0  initial release
// ============================================================================
module mul_int_iter
  import alu_mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DIGITS_PER_CYC = 2,
  parameter int OUT_FLOP_EN    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] res_o
);

  localparam int c_ew = WIDTH + 2;
  localparam int c_aw = 2*WIDTH + 4;
  localparam int c_n  = (WIDTH + 2) / 2;
  localparam int c_cw = $clog2(c_n + DIGITS_PER_CYC + 1);
  localparam int c_bw = c_ew + 1 + 2*DIGITS_PER_CYC;

  state_e                      r_state;
  mul_op_e                     r_op;
  logic [c_ew-1:0]             r_a_ext;
  logic [c_bw-1:0]             r_b_sh;   // {pad, b_ext, b[-1]=0}, shifted per step
  logic [c_aw-1:0]             r_acc;
  logic [c_cw-1:0]             r_cnt;
  logic [WIDTH-1:0]            r_res;
  logic                        r_out_vld;

  logic [c_aw-1:0]             w_acc_next;
  logic [c_cw-1:0]             w_cnt_next;
  logic [3*DIGITS_PER_CYC-1:0] w_trip;
  logic                        w_last;
  logic                        w_accept;
  logic                        w_a_sgn;
  logic                        w_b_sgn;
  logic [c_ew-1:0]             w_a_cap;
  logic [c_ew-1:0]             w_b_cap;
  logic [WIDTH-1:0]            w_res_sel;

  assign w_a_sgn = (op_i == MULH) || (op_i == MULHSU);
  assign w_b_sgn = (op_i == MULH);
  assign w_a_cap = {{2{w_a_sgn & a_i[WIDTH-1]}}, a_i};
  assign w_b_cap = {{2{w_b_sgn & b_i[WIDTH-1]}}, b_i};

  // Kill wins over any handoff in the same cycle.
  assign in_rdy_o = !kill_i && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_rdy_i));
  assign w_accept = in_vld_i && in_rdy_o;

  assign w_cnt_next = r_cnt + c_cw'(DIGITS_PER_CYC);
  assign w_last     = (r_state == S_BUSY) && (w_cnt_next >= c_cw'(c_n));

  // The low bit triplets of the shift register are always the next digits.
  genvar gj;
  generate
    for (gj = 0; gj < DIGITS_PER_CYC; gj++) begin : g_trip
      assign w_trip[3*gj +: 3] = r_b_sh[2*gj +: 3];
    end
  endgenerate

  mul_booth_step #(
    .WIDTH          (WIDTH),
    .DIGITS_PER_CYC (DIGITS_PER_CYC),
    .CNT_W          (c_cw)
  ) u_step (
    .i_acc   (r_acc),
    .i_a_ext (r_a_ext),
    .i_trip  (w_trip),
    .i_base  (r_cnt),
    .o_acc   (w_acc_next)
  );

  assign w_res_sel = (r_op == MUL) ? w_acc_next[WIDTH-1:0] : w_acc_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_op      <= MUL;
      r_a_ext   <= '0;
      r_b_sh    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_out_vld <= 1'b0;
    end else if (kill_i) begin
      r_state   <= S_IDLE;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_BUSY: begin
          r_acc  <= w_acc_next;
          r_cnt  <= w_cnt_next;
          r_b_sh <= r_b_sh >> (2*DIGITS_PER_CYC);
          if (w_last) begin
            r_res <= w_res_sel;
            // Unregistered mode: a consumer taking the result during the
            // final step skips DONE entirely.
            if (OUT_FLOP_EN == 0 && out_rdy_i) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DONE;
              r_out_vld <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_rdy_i) begin
            r_state   <= S_IDLE;
            r_out_vld <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Acceptance from IDLE or a same-cycle handoff out of DONE.
      if (w_accept) begin
        r_state <= S_BUSY;
        r_op    <= mul_op_e'(op_i);
        r_a_ext <= w_a_cap;
        r_b_sh  <= {{(2*DIGITS_PER_CYC){1'b0}}, w_b_cap, 1'b0};
        r_acc   <= '0;
        r_cnt   <= '0;
      end
    end
  end

  generate
    if (OUT_FLOP_EN != 0) begin : g_out_flop
      assign out_vld_o = r_out_vld;
      assign res_o     = r_res;
    end else begin : g_out_comb
      assign out_vld_o = r_out_vld | (w_last & ~kill_i & ~rst_i);
      assign res_o     = w_last ? w_res_sel : r_res;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mul_int_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_int_iter
// Purpose  : Self-checking bench for mul_int_iter. Three instances:
//            unit 0: WIDTH=16 DPC=1 registered; unit 1: WIDTH=32 DPC=4
//            registered; unit 2: WIDTH=8 DPC=2 unregistered output.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_int_iter;
  import alu_mul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld  [3];
  logic [1:0]  opv  [3];
  logic [31:0] av   [3];
  logic [31:0] bv   [3];
  logic        kill [3];
  logic        ordy [3];

  logic        irdy0, ovld0, irdy1, ovld1, irdy2, ovld2;
  logic [15:0] res0;
  logic [31:0] res1;
  logic [7:0]  res2;

  mul_int_iter #(.WIDTH(16), .DIGITS_PER_CYC(1), .OUT_FLOP_EN(1)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .in_vld_i(vld[0]), .in_rdy_o(irdy0), .op_i(opv[0]),
    .a_i(av[0][15:0]), .b_i(bv[0][15:0]), .kill_i(kill[0]), .out_vld_o(ovld0),
    .out_rdy_i(ordy[0]), .res_o(res0));

  mul_int_iter #(.WIDTH(32), .DIGITS_PER_CYC(4), .OUT_FLOP_EN(1)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .in_vld_i(vld[1]), .in_rdy_o(irdy1), .op_i(opv[1]),
    .a_i(av[1]), .b_i(bv[1]), .kill_i(kill[1]), .out_vld_o(ovld1),
    .out_rdy_i(ordy[1]), .res_o(res1));

  mul_int_iter #(.WIDTH(8), .DIGITS_PER_CYC(2), .OUT_FLOP_EN(0)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .in_vld_i(vld[2]), .in_rdy_o(irdy2), .op_i(opv[2]),
    .a_i(av[2][7:0]), .b_i(bv[2][7:0]), .kill_i(kill[2]), .out_vld_o(ovld2),
    .out_rdy_i(ordy[2]), .res_o(res2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic get_irdy(input int u);
    case (u)
      0:       return irdy0;
      1:       return irdy1;
      default: return irdy2;
    endcase
  endfunction

  function automatic logic get_ovld(input int u);
    case (u)
      0:       return ovld0;
      1:       return ovld1;
      default: return ovld2;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int u);
    case (u)
      0:       return 32'(res0);
      1:       return res1;
      default: return 32'(res2);
    endcase
  endfunction

  function automatic int uw(input int u);
    case (u)
      0:       return 16;
      1:       return 32;
      default: return 8;
    endcase
  endfunction

  // Expected cycles from acceptance to first out_vld.
  function automatic int exp_lat(input int u);
    int w, d, f, n, c;
    case (u)
      0:       begin w = 16; d = 1; f = 1; end
      1:       begin w = 32; d = 4; f = 1; end
      default: begin w = 8;  d = 2; f = 0; end
    endcase
    n = (w + 2) / 2;
    c = (n + d - 1) / d;
    return c + f;
  endfunction

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: plain signed/unsigned integer product, then pick a half.
  function automatic logic [31:0] ref_mul(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] m;
    m  = wmask(w);
    sa = longint'(a & m);
    sb = longint'(b & m);
    if ((op == MULH || op == MULHSU) && a[w-1]) sa = sa - (longint'(1) << w);
    if (op == MULH && b[w-1])                   sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    if (op == MUL) return 32'(p) & m;
    return 32'(p >> w) & m;
  endfunction

  function automatic logic [31:0] rnd_opnd(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd1 << (w - 1);
      3:       v = (32'd1 << (w - 1)) - 32'd1;
      default: v = $urandom;
    endcase
    return v & wmask(w);
  endfunction

  // One full transaction; returns result and acceptance-to-valid latency.
  task automatic do_op(input int u, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int stall,
                       output logic [31:0] res, output int lat);
    int guard;
    bit stable;
    @(negedge clk);
    vld[u] = 1'b1; opv[u] = op; av[u] = a; bv[u] = b;
    #1;
    guard = 0;
    while (!get_irdy(u) && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    chk("accept wait", 32'(get_irdy(u)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    vld[u] = 1'b0;
    #1;
    lat = 1;
    while (!get_ovld(u) && lat < 100) begin
      @(negedge clk); #1; lat++;
    end
    res = get_res(u);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      if (get_res(u) !== res || !get_ovld(u)) stable = 1'b0;
    end
    if (stall > 0) chk("stall hold", 32'(stable), 32'd1);
    ordy[u] = 1'b1;
    @(negedge clk);
    ordy[u] = 1'b0;
  endtask

  typedef struct {
    int          u;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] r, e;
    int          lat;
    bit          seen;
    int          nrand [3];

    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      vld[u] = 1'b0; opv[u] = 2'd0; av[u] = '0; bv[u] = '0; kill[u] = 1'b0; ordy[u] = 1'b0;
    end

    tbl[0]  = '{0, MULHU,  32'hFFFF,      32'hFFFF,      32'hFFFE};
    tbl[1]  = '{0, MUL,    32'hFFFF,      32'hFFFF,      32'h0001};
    tbl[2]  = '{0, MULH,   32'hFFFF,      32'hFFFF,      32'h0000};
    tbl[3]  = '{0, MULH,   32'h8000,      32'h8000,      32'h4000};
    tbl[4]  = '{0, MULHSU, 32'hFFFF,      32'hFFFF,      32'hFFFF};
    tbl[5]  = '{0, MUL,    32'h0003,      32'h0005,      32'h000F};
    tbl[6]  = '{1, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[7]  = '{1, MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[8]  = '{1, MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[9]  = '{1, MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    tbl[10] = '{1, MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    tbl[11] = '{1, MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[12] = '{2, MULHU,  32'hFF,        32'hFF,        32'hFE};
    tbl[13] = '{2, MULH,   32'h80,        32'h80,        32'h40};
    tbl[14] = '{2, MULHSU, 32'h80,        32'hFF,        32'h80};
    tbl[15] = '{2, MUL,    32'h0D,        32'h0B,        32'h8F};
    tbl[16] = '{2, MULH,   32'h7F,        32'h80,        32'hC0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset in_rdy u%0d", u),  32'(get_irdy(u)), 32'd1);
      chk($sformatf("reset out_vld u%0d", u), 32'(get_ovld(u)), 32'd0);
      chk($sformatf("reset res u%0d", u),     get_res(u),       32'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      do_op(tbl[i].u, tbl[i].op, tbl[i].a, tbl[i].b, 0, r, lat);
      chk($sformatf("vec%0d res", i), r, tbl[i].exp);
      chk($sformatf("vec%0d lat", i), 32'(lat), 32'(exp_lat(tbl[i].u)));
    end

    // Consumer stalls for 3 cycles; result must hold.
    do_op(1, MULHSU, 32'hDEAD_BEEF, 32'h1234_5678, 3, r, lat);
    chk("stall res", r, ref_mul(32, MULHSU, 32'hDEAD_BEEF, 32'h1234_5678));

    // Back-to-back handoff out of DONE.
    @(negedge clk);
    vld[1] = 1'b1; opv[1] = MUL; av[1] = 32'd7; bv[1] = 32'd9;
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    #1;
    lat = 1;
    while (!ovld1 && lat < 100) begin @(negedge clk); #1; lat++; end
    chk("b2b first res", res1, 32'd63);
    ordy[1] = 1'b1; vld[1] = 1'b1; opv[1] = MULHU; av[1] = 32'hFFFF_FFFF; bv[1] = 32'd2;
    #1;
    chk("b2b handoff rdy", 32'(irdy1), 32'd1);
    @(negedge clk);
    ordy[1] = 1'b0; vld[1] = 1'b0;
    #1;
    chk("b2b busy flags", {30'd0, ovld1, irdy1}, 32'd0);
    lat = 1;
    while (!ovld1 && lat < 100) begin @(negedge clk); #1; lat++; end
    chk("b2b second lat", 32'(lat), 32'(exp_lat(1)));
    chk("b2b second res", res1, 32'd1);
    ordy[1] = 1'b1;
    @(negedge clk);
    ordy[1] = 1'b0;

    // Kill on the 3rd BUSY cycle.
    @(negedge clk);
    vld[1] = 1'b1; opv[1] = MULHU; av[1] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk); vld[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); kill[1] = 1'b1;
    @(negedge clk); kill[1] = 1'b0;
    #1;
    chk("kill busy out_vld", 32'(ovld1), 32'd0);
    chk("kill busy in_rdy",  32'(irdy1), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); #1; if (ovld1) seen = 1'b1; end
    chk("kill busy no result", 32'(seen), 32'd0);
    do_op(1, MUL, 32'd3, 32'd5, 0, r, lat);
    chk("after kill res", r, 32'h0000_000F);

    // Reset on the 2nd BUSY cycle.
    @(negedge clk);
    vld[0] = 1'b1; opv[0] = MULHU; av[0] = 32'hFFFF; bv[0] = 32'hFFFF;
    @(posedge clk);
    @(negedge clk); vld[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst busy out_vld", 32'(ovld0), 32'd0);
    chk("rst busy in_rdy",  32'(irdy0), 32'd1);
    chk("rst busy res",     32'(res0),  32'd0);
    do_op(0, MUL, 32'd3, 32'd5, 0, r, lat);
    chk("after rst res", r, 32'h0000_000F);
    chk("after rst lat", 32'(lat), 32'(exp_lat(0)));

    // Kill while the result is waiting in DONE.
    @(negedge clk);
    vld[1] = 1'b1; opv[1] = MUL; av[1] = 32'd11; bv[1] = 32'd13;
    @(posedge clk);
    @(negedge clk); vld[1] = 1'b0;
    #1;
    lat = 1;
    while (!ovld1 && lat < 100) begin @(negedge clk); #1; lat++; end
    chk("kill done seen vld", 32'(ovld1), 32'd1);
    kill[1] = 1'b1;
    @(negedge clk); kill[1] = 1'b0;
    #1;
    chk("kill done out_vld", 32'(ovld1), 32'd0);
    chk("kill done in_rdy",  32'(irdy1), 32'd1);

    // Kill in IDLE blocks the request presented in that cycle.
    @(negedge clk);
    vld[2] = 1'b1; kill[2] = 1'b1; opv[2] = MUL; av[2] = 32'd3; bv[2] = 32'd5;
    @(posedge clk);
    @(negedge clk); vld[2] = 1'b0; kill[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin #1; if (ovld2) seen = 1'b1; @(negedge clk); end
    chk("kill idle no accept", 32'(seen), 32'd0);

    // Randomised traffic against the reference model.
    nrand[0] = 300; nrand[1] = 2000; nrand[2] = 400;
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < nrand[u]; i++) begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          st;
        op = 2'($urandom_range(0, 3));
        a  = rnd_opnd(uw(u));
        b  = rnd_opnd(uw(u));
        st = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
        e  = ref_mul(uw(u), op, a, b);
        do_op(u, op, a, b, st, r, lat);
        if (r !== e)
          chk($sformatf("rand u%0d op%0d a=%0h b=%0h", u, op, a, b), r, e);
        else
          chk("rand res", r, e);
        chk("rand lat", 32'(lat), 32'(exp_lat(u)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
